osc_to_temp: RTL and testbench



---
 rtl/osc_to_temp.sv | 167 ++++++++++++++++
 tb/tb_osc_to_temp.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/osc_to_temp.sv
// Ring-oscillator frequency to calibrated temperature (0.1 C units).
// Gated edge count followed by a 16-cycle shift-add linear calibration.
module osc_to_temp #(
  parameter int unsigned      GATE_CYCLES = 1000000,
  parameter int unsigned      CNT_W       = 20,
  parameter logic [CNT_W-1:0] CNT_OFFSET  = '0,
  parameter logic [15:0]      SLOPE       = 16'd1,
  parameter int unsigned      SLOPE_SHIFT = 0,
  parameter int unsigned      TEMP_MAX    = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sens_osc,
  output logic [9:0] temp,
  output logic       oor,
  output logic       start
);

  localparam int unsigned      GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned      PW        = CNT_W + 16;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONES  = '1;
  localparam logic [PW-1:0]    RES_MAX   = PW'(TEMP_MAX);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SUB = 2'd1, S_MUL = 2'd2, S_DONE = 2'd3} state_t;

  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt, r_meas;
  logic [GW-1:0]    r_gate_ctr;
  state_t           r_state, w_state_nxt;
  logic             r_bad;
  logic [PW-1:0]    r_mcand, r_acc;
  logic [3:0]       r_iter;
  logic [9:0]       r_temp;
  logic             r_oor, r_start;

  logic             w_edge, w_capture;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_do_sub, w_do_mul, w_do_done;
  logic [PW-1:0]    w_res;
  logic             w_oor;
  logic [9:0]       w_temp;

  // sens_osc is asynchronous: two flops to resolve metastability, third for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sens_osc;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_comb begin
    w_edge    = r_s2 & ~r_s3;
    w_capture = (r_gate_ctr == GATE_LAST);
    if (w_edge && (r_cnt != CNT_ONES)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate_ctr <= '0;
      r_cnt      <= '0;
      r_meas     <= '0;
    end else begin
      if (w_capture) begin
        r_gate_ctr <= '0;
        r_cnt      <= '0;
      end else begin
        r_gate_ctr <= r_gate_ctr + GW'(1);
        r_cnt      <= w_cnt_nxt;
      end
      // meas includes an edge landing on the capture cycle; frozen while busy
      if (w_capture && (r_state == S_IDLE)) begin
        r_meas <= w_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_capture ? S_SUB : S_IDLE;
      S_SUB:   w_state_nxt = S_MUL;
      S_MUL:   w_state_nxt = (r_iter == 4'd15) ? S_DONE : S_MUL;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_do_sub  = 1'b0;
    w_do_mul  = 1'b0;
    w_do_done = 1'b0;
    case (r_state)
      S_SUB:   w_do_sub  = 1'b1;
      S_MUL:   w_do_mul  = 1'b1;
      S_DONE:  w_do_done = 1'b1;
      default: w_do_sub  = 1'b0;
    endcase
  end

  // LSB-first shift-add: multiplicand doubles each step, SLOPE bit selects the add
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bad   <= 1'b0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_iter  <= 4'd0;
    end else if (w_do_sub) begin
      r_bad   <= (r_meas == '0) | (r_meas == CNT_ONES) | (r_meas < CNT_OFFSET);
      r_mcand <= {16'd0, r_meas - CNT_OFFSET};
      r_acc   <= '0;
      r_iter  <= 4'd0;
    end else if (w_do_mul) begin
      if (SLOPE[r_iter]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand <= r_mcand << 1;
      r_iter  <= r_iter + 4'd1;
    end
  end

  always_comb begin
    w_res = r_acc >> SLOPE_SHIFT;
    w_oor = r_bad | (w_res > RES_MAX);
    if (w_oor) begin
      w_temp = 10'd0;
    end else begin
      w_temp = w_res[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_temp  <= 10'd0;
      r_oor   <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_do_done;
      if (w_do_done) begin
        r_temp <= w_temp;
        r_oor  <= w_oor;
      end
    end
  end

  assign temp  = r_temp;
  assign oor   = r_oor;
  assign start = r_start;

endmodule

// File: tb/tb_osc_to_temp.sv
// Directed bench for osc_to_temp: several parameterisations run side by side,
// checked with immediate assertions against hand-computed values.
module tb_osc_to_temp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst_g;
  logic osc10, osc6, osc_hi;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [9:0] t [7];
  logic       o [7];
  logic       s [7];
  int         nst [7] = '{0, 0, 0, 0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  // clk/10 oscillator: rising at 3 + 100*m ns, away from clk edges
  initial begin
    osc10 = 1'b0;
    #3;
    forever begin
      osc10 = ~osc10;
      #50;
    end
  end

  // clk/6 oscillator
  initial begin
    osc6 = 1'b0;
    #2;
    forever begin
      osc6 = ~osc6;
      #30;
    end
  end

  initial osc_hi = 1'b1;

  always @(negedge clk) begin
    for (int k = 0; k < 7; k++) begin
      if (s[k]) nst[k] <= nst[k] + 1;
    end
  end

  osc_to_temp #(.GATE_CYCLES(1000)) u0 (
    .clk(clk), .rst(rst0), .sens_osc(osc10), .temp(t[0]), .oor(o[0]), .start(s[0]));
  osc_to_temp #(.GATE_CYCLES(3000), .CNT_OFFSET(20'd250), .SLOPE(16'd3), .SLOPE_SHIFT(1)) u1 (
    .clk(clk), .rst(rst_g), .sens_osc(osc6), .temp(t[1]), .oor(o[1]), .start(s[1]));
  osc_to_temp #(.GATE_CYCLES(1998), .SLOPE(16'd6), .SLOPE_SHIFT(1)) u2 (
    .clk(clk), .rst(rst_g), .sens_osc(osc6), .temp(t[2]), .oor(o[2]), .start(s[2]));
  osc_to_temp #(.GATE_CYCLES(2400), .SLOPE(16'd5), .SLOPE_SHIFT(1)) u3 (
    .clk(clk), .rst(rst_g), .sens_osc(osc6), .temp(t[3]), .oor(o[3]), .start(s[3]));
  osc_to_temp #(.GATE_CYCLES(1200), .CNT_OFFSET(20'd250)) u4 (
    .clk(clk), .rst(rst_g), .sens_osc(osc6), .temp(t[4]), .oor(o[4]), .start(s[4]));
  osc_to_temp #(.GATE_CYCLES(1000)) u5 (
    .clk(clk), .rst(rst_g), .sens_osc(osc_hi), .temp(t[5]), .oor(o[5]), .start(s[5]));
  osc_to_temp #(.GATE_CYCLES(200), .CNT_W(4)) u6 (
    .clk(clk), .rst(rst_g), .sens_osc(osc10), .temp(t[6]), .oor(o[6]), .start(s[6]));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start0(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (s[0]) begin
        at = cyc;
        break;
      end
    end
  endtask

  int at;
  int gate [7]    = '{1000, 3000, 1998, 2400, 1200, 1000, 200};
  int exp_t [7]   = '{100, 375, 999, 0, 0, 0, 0};
  int exp_o [7]   = '{0, 0, 0, 1, 1, 1, 1};
  int first_st;
  int exp_n;

  initial begin
    rst0  = 1'b1;
    rst_g = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_temp", int'(t[0]), 0);
    check("rst_oor", int'(o[0]), 0);
    check("rst_start", int'(s[0]), 0);
    check("rst_temp_u1", int'(t[1]), 0);

    // shared reset: first posedge with rst low is cycle 5
    while (cyc < 4) @(negedge clk);
    rst_g = 1'b0;
    // u0 released so its first sampled cycle is 10 (aligned to osc10 phase)
    while (cyc < 9) @(negedge clk);
    rst0 = 1'b0;

    // capture at 10+999, start 18 edges later
    wait_start0(1100, at);
    check("first_start_cyc", at, 1027);
    check("first_temp", int'(t[0]), 100);
    check("first_oor", int'(o[0]), 0);
    @(negedge clk);
    check("start_width", int'(s[0]), 0);

    wait_start0(1100, at);
    check("second_start_cyc", at, 2027);
    check("second_temp", int'(t[0]), 100);

    while (cyc < 2500) @(negedge clk);
    check("hold_temp", int'(t[0]), 100);
    check("hold_start", int'(s[0]), 0);

    // next capture at 3009; MUL spans edges 3011..3026; reset lands on edge 3019
    while (cyc < 3018) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check("midrst_temp", int'(t[0]), 0);
    check("midrst_oor", int'(o[0]), 0);
    wait_start0(1100, at);
    check("post_rst_start_cyc", at, 4037);
    check("post_rst_temp", int'(t[0]), 100);
    check("post_rst_oor", int'(o[0]), 0);

    while (cyc < 6100) @(negedge clk);
    for (int k = 1; k < 7; k++) begin
      first_st = 5 + gate[k] + 17;
      exp_n = (6100 >= first_st) ? ((6100 - first_st) / gate[k] + 1) : 0;
      check($sformatf("u%0d_nstart", k), nst[k], exp_n);
      check($sformatf("u%0d_temp", k), int'(t[k]), exp_t[k]);
      check($sformatf("u%0d_oor", k), int'(o[k]), exp_o[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
